alu_seq_unit: RTL and testbench
===============================

// Module: alu_seq_unit
// PURPOSE
//   Registered, handshaked ALU responder that accepts one operation per request and returns one
//   result. Ops are ADD, SUB, MUL and AND over two W-bit operands. MUL runs as a W-cycle
//   shift-add sequence. Sits between a command driver (bench or sequencer) and a result consumer.
// PARAMETERS
//   W  8  operand/result width in bits (W >= 2)
// PORTS
//   clk        in   1    single clock; all state updates on rising edge
//   rst_n      in   1    synchronous, active-low reset (sampled on rising clk edge)
//   in_valid   in   1    request valid
//   in_ready   out  1    unit can accept request
//   a          in   W    operand A
//   b          in   W    operand B
//   sel        in   2    op: 00 ADD, 01 SUB (a-b), 10 MUL (low W bits), 11 AND
//   out_valid  out  1    result valid
//   out_ready  in   1    consumer takes result
//   result     out  W    op result
//   carry      out  1    ADD: carry-out; SUB: borrow (a<b unsigned); MUL: upper W bits nonzero; AND: 0
//   busy       out  1    high in any state other than IDLE
// BEHAVIOUR
// - Reset (rst_n=0 at clk edge): state=IDLE, in_ready=1, out_valid=0, result=0, carry=0, busy=0.
//   Reset overrides everything, including a MUL in progress; partial product is discarded.
// - Accept: in_valid & in_ready at a clk edge latches a, b, sel. in_ready = (state==IDLE).
// - FSM states: IDLE, EXEC, DONE.
//   IDLE -> DONE on accept with sel!=10; result/carry registered on that same edge.
//   IDLE -> EXEC on accept with sel==10; acc=0 (2W bits), mcand=a zero-extended, mplier=b, cnt=0.
//   EXEC: each cycle, if mplier[0] then acc+=mcand; mcand<<=1; mplier>>=1; cnt++.
//         after W EXEC cycles (cnt==W-1 step) -> DONE; result=acc[W-1:0], carry=|acc[2W-1:W].
//   DONE: out_valid=1, result/carry held stable; out_valid & out_ready -> IDLE.
// - Latency (accept edge to out_valid high): ADD/SUB/AND 1 cycle; MUL W+1 cycles. Fixed
//   latency regardless of operand values (MUL by 0 still takes W EXEC cycles).
// - Arithmetic: unsigned, modulo 2^W. ADD {carry,result}=a+b. SUB result=a-b mod 2^W,
//   carry=(a<b). AND result=a&b.
// - Backpressure: out_ready low in DONE holds out_valid, result, carry indefinitely.
//   in_ready stays 0 until the result is consumed. Inputs a/b/sel are ignored outside an
//   accept edge; changes during EXEC/DONE do not affect the result.
// - Throughput: no overlap. Next accept happens at the earliest on the edge after the result
//   handshake. Max rate is one simple op per 2 cycles.
// - in_valid while in_ready=0: request is not taken; the driver must hold it until accepted.
// - out_ready while out_valid=0: no effect.
// - After the DONE->IDLE handshake, result/carry keep their last values; out_valid=0.
// TESTING
// 1 Reset: rst_n=0 for 2 cycles mid-MUL -> in_ready=1, out_valid=0, result=0, carry=0,
//   busy=0. The next ADD completes normally.
// 2 a=0x15 b=0x1C with sel=00/01/11, out_ready=1 -> results 0x31/c0, 0xF9/c1, 0x14/c0.
//   out_valid rises 1 cycle after accept for each op.
// 3 MUL a=0x15 b=0x1C -> result=0x4C, carry=1, out_valid exactly 9 cycles after accept,
//   busy high throughout. MUL a=0xFF b=0x00 -> 0x00/c0, also 9 cycles.
// 4 ADD a=0x15 b=0x9C; ADD a=0xFF b=0x01 -> 0xB1/c0 and 0x00/c1 (wrap-around).
// 5 Backpressure: out_ready=0 for 5 cycles after out_valid -> result stable, in_ready=0.
//   A new request pending on in_valid is accepted only on the edge after out_ready=1.
// 6 Back-to-back: AND a=0x01 b=0x1C held on in_valid continuously -> result 0x00/c0.
//   Accepts occur every 2nd cycle with out_ready=1; no request is lost or duplicated.
//   A scoreboard count of accepts equals the count of results.

Source files
------------

// File: rtl/alu_seq_unit_if.sv
// Request/response bundle between a command driver and the sequential ALU.
// The driver side owns the request fields and out_ready; the ALU side owns the rest.
interface alu_seq_unit_if #(
  parameter int W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [1:0]   sel;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         busy;

  modport master (
    output in_valid, a, b, sel, out_ready,
    input  in_ready, out_valid, result, carry, busy
  );

  modport slave (
    input  in_valid, a, b, sel, out_ready,
    output in_ready, out_valid, result, carry, busy
  );
endinterface

// File: rtl/alu_seq_unit.sv
// Handshaked ALU with one operation in flight: ADD/SUB/AND finish in one step,
// MUL runs as a W-step shift-add before the result is offered.
module alu_seq_unit #(
  parameter int W = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  alu_seq_unit_if.slave   bus
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] CNT_LAST = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    DONE
  } state_e;

  state_e          state_q, state_d;
  logic [2*W-1:0]  acc_q, acc_d;
  logic [2*W-1:0]  mcand_q, mcand_d;
  logic [W-1:0]    mplier_q, mplier_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    result_q, result_d;
  logic            carry_q, carry_d;
  logic [2*W-1:0]  acc_step;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      carry_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      carry_q  <= carry_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    carry_d  = carry_q;
    acc_step = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          unique case (bus.sel)
            2'b00: begin
              {carry_d, result_d} = {1'b0, bus.a} + {1'b0, bus.b};
              state_d             = DONE;
            end
            2'b01: begin
              result_d = bus.a - bus.b;
              carry_d  = (bus.a < bus.b);
              state_d  = DONE;
            end
            2'b11: begin
              result_d = bus.a & bus.b;
              carry_d  = 1'b0;
              state_d  = DONE;
            end
            default: begin
              acc_d    = '0;
              mcand_d  = {{W{1'b0}}, bus.a};
              mplier_d = bus.b;
              cnt_d    = '0;
              state_d  = EXEC;
            end
          endcase
        end
      end
      EXEC: begin
        // Always W steps, even when the multiplier runs out of ones early.
        acc_d    = acc_step;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CNT_LAST) begin
          result_d = acc_step[W-1:0];
          carry_d  = |acc_step[2*W-1:W];
          state_d  = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.in_ready  = (state_q == IDLE);
    bus.out_valid = (state_q == DONE);
    bus.busy      = (state_q != IDLE);
    bus.result    = result_q;
    bus.carry     = carry_q;
  end

endmodule

// File: tb/tb_alu_seq_unit.sv
// Directed bench for alu_seq_unit: stimulus pushes expected results into a queue,
// an independent negedge monitor checks latency, hold stability and values.
module tb_alu_seq_unit;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] res;
    logic         c;
    int           lat;
  } exp_t;

  logic clk;
  logic rst_n;

  alu_seq_unit_if #(.W(W)) bus ();

  alu_seq_unit #(.W(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t exp_q[$];
  int   n_checks     = 0;
  int   n_fails      = 0;
  int   cyc          = 0;
  int   acc_count    = 0;
  int   res_count    = 0;
  int   issued_count = 0;
  int   acc_cyc      = 0;
  bit   pend         = 1'b0;
  bit   seen         = 1'b0;
  logic [W-1:0] held_res;
  logic         held_c;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkInt(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_in_ready"},  W'(bus.in_ready),  8'h01);
    checkOutput({tag, "_out_valid"}, W'(bus.out_valid), 8'h00);
    checkOutput({tag, "_result"},    bus.result,        8'h00);
    checkOutput({tag, "_carry"},     W'(bus.carry),     8'h00);
    checkOutput({tag, "_busy"},      W'(bus.busy),      8'h00);
  endtask

  // Called at posedge+1; raises the request at once so consecutive calls hold in_valid high.
  task automatic applyStimulus(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic [1:0] isel,
                               input logic [W-1:0] eres, input logic ec, input int elat,
                               input bit push, output int acc_at);
    exp_t e;
    bit   taken;
    if (push) begin
      e.res = eres;
      e.c   = ec;
      e.lat = elat;
      exp_q.push_back(e);
      issued_count++;
    end
    bus.a        = ia;
    bus.b        = ib;
    bus.sel      = isel;
    bus.in_valid = 1'b1;
    taken        = 1'b0;
    acc_at       = -1;
    for (int i = 0; i < 100 && !taken; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin
        @(posedge clk);
        #1;
        acc_at = cyc;
        taken  = 1'b1;
      end
    end
    bus.in_valid = 1'b0;
    if (!taken) begin
      n_checks++;
      n_fails++;
      $display("[TB] FAIL accept_timeout: got no accept, expected accept within 100 cycles");
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    #1;
    checkInt("drain_pending", exp_q.size(), 0);
  endtask

  // Monitor: in-flight status, first-valid latency, hold stability, result handshake, accepts.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      pend = 1'b0;
      seen = 1'b0;
    end else begin
      if (pend) begin
        checkOutput("busy_in_flight",     W'(bus.busy),     8'h01);
        checkOutput("in_ready_in_flight", W'(bus.in_ready), 8'h00);
      end
      if (bus.out_valid) begin
        if (!seen) begin
          seen     = 1'b1;
          held_res = bus.result;
          held_c   = bus.carry;
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fails++;
            $display("[TB] FAIL unexpected_output: got result 0x%0h, expected none", bus.result);
          end else begin
            checkInt("latency", cyc - acc_cyc + 1, exp_q[0].lat);
          end
        end else begin
          checkOutput("hold_result", bus.result,    held_res);
          checkOutput("hold_carry",  W'(bus.carry), W'(held_c));
        end
        if (bus.out_ready) begin
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checkOutput("result", bus.result,    e.res);
            checkOutput("carry",  W'(bus.carry), W'(e.c));
          end
          res_count++;
          pend = 1'b0;
          seen = 1'b0;
        end
      end
      if (bus.in_valid && bus.in_ready) begin
        pend    = 1'b1;
        acc_cyc = cyc + 1;
        acc_count++;
      end
    end
  end

  initial begin
    int acc_at;
    int last_acc;
    int ready_cyc;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.a         = '0;
    bus.b         = '0;
    bus.sel       = 2'b00;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("init");
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] reset during MUL");
    applyStimulus(8'h15, 8'h1C, 2'b10, 8'h00, 1'b0, 0, 1'b0, acc_at);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkReset("mid_mul");
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    acc_count = 0;
    res_count = 0;
    applyStimulus(8'h15, 8'h1C, 2'b00, 8'h31, 1'b0, 1, 1'b1, acc_at);
    drain();

    $display("[TB] simple ops");
    applyStimulus(8'h15, 8'h1C, 2'b00, 8'h31, 1'b0, 1, 1'b1, acc_at);
    applyStimulus(8'h15, 8'h1C, 2'b01, 8'hF9, 1'b1, 1, 1'b1, acc_at);
    applyStimulus(8'h15, 8'h1C, 2'b11, 8'h14, 1'b0, 1, 1'b1, acc_at);
    drain();

    $display("[TB] multiply");
    applyStimulus(8'h15, 8'h1C, 2'b10, 8'h4C, 1'b1, W + 1, 1'b1, acc_at);
    applyStimulus(8'hFF, 8'h00, 2'b10, 8'h00, 1'b0, W + 1, 1'b1, acc_at);
    applyStimulus(8'h0F, 8'h11, 2'b10, 8'hFF, 1'b0, W + 1, 1'b1, acc_at);
    drain();

    $display("[TB] add wrap-around");
    applyStimulus(8'h15, 8'h9C, 2'b00, 8'hB1, 1'b0, 1, 1'b1, acc_at);
    applyStimulus(8'hFF, 8'h01, 2'b00, 8'h00, 1'b1, 1, 1'b1, acc_at);
    applyStimulus(8'h05, 8'h05, 2'b01, 8'h00, 1'b0, 1, 1'b1, acc_at);
    drain();

    $display("[TB] backpressure");
    bus.out_ready = 1'b0;
    applyStimulus(8'h40, 8'h22, 2'b01, 8'h1E, 1'b0, 1, 1'b1, acc_at);
    ready_cyc = 0;
    fork
      applyStimulus(8'h80, 8'h80, 2'b00, 8'h00, 1'b1, 1, 1'b1, last_acc);
      begin
        repeat (5) @(posedge clk);
        #1;
        ready_cyc     = cyc;
        bus.out_ready = 1'b1;
      end
    join
    checkInt("bp_accept_cycle", last_acc, ready_cyc + 2);
    drain();

    $display("[TB] back-to-back");
    last_acc = 0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(8'h01, 8'h1C, 2'b11, 8'h00, 1'b0, 1, 1'b1, acc_at);
      if (i > 0) checkInt("b2b_spacing", acc_at - last_acc, 2);
      last_acc = acc_at;
    end
    drain();

    repeat (2) @(posedge clk);
    #1;
    checkInt("accepts_vs_results", acc_count, res_count);
    checkInt("results_vs_issued",  res_count, issued_count);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
